bc_id_scoreboard: RTL and testbench

BC_ID_SCOREBOARD -- requirements
Module: bc_id_scoreboard

---
 rtl/bc_id_scoreboard.sv | 119 +++++++++++
 tb/tb_bc_id_scoreboard.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_id_scoreboard.sv
// bc_id_scoreboard: decode-stage register scoreboard.
// Each architectural register 1..31 has a small counter of writes that have
// issued but not yet been written back. Decode may issue only when its source
// registers have no pending writes and its destination counter has headroom.
// A writeback that lands in the same cycle is bypassed into the ready check.

module bc_id_scoreboard #(
    parameter int CNT_WIDTH       = 2,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_id_valid,
    output logic                       o_id_ready,
    input  logic                       i_rs1_used,
    input  logic [4:0]                 i_rs1_addr,
    input  logic                       i_rs2_used,
    input  logic [4:0]                 i_rs2_addr,
    input  logic                       i_rd_wen,
    input  logic [4:0]                 i_rd_addr,
    input  logic                       i_wb_valid,
    input  logic [4:0]                 i_wb_addr,
    input  logic                       i_flush,
    output logic                       o_busy,
    output logic                       o_underflow,
    output logic [STALL_CNT_WIDTH-1:0] o_stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Entry 0 exists only so x0 can be indexed like any other register; it is
    // held at zero, which makes x0 look permanently free.
    logic [CNT_WIDTH-1:0] cnt [32];

    logic                 wb_retire;
    logic                 wb_underflow;
    logic                 issue;
    logic                 rd_inc;
    logic                 any_pending;
    logic [CNT_WIDTH-1:0] rs1_eff;
    logic [CNT_WIDTH-1:0] rs2_eff;
    logic [CNT_WIDTH-1:0] rd_eff;

    // Hazard evaluation: effective counts with same-cycle writeback bypass.
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        wb_retire    = i_wb_valid && (i_wb_addr != 5'd0) && (cnt[i_wb_addr] != '0);
        wb_underflow = i_wb_valid && (i_wb_addr != 5'd0) && (cnt[i_wb_addr] == '0);

        rs1_eff = cnt[i_rs1_addr] - CNT_WIDTH'(wb_retire && (i_wb_addr == i_rs1_addr));
        rs2_eff = cnt[i_rs2_addr] - CNT_WIDTH'(wb_retire && (i_wb_addr == i_rs2_addr));
        rd_eff  = cnt[i_rd_addr]  - CNT_WIDTH'(wb_retire && (i_wb_addr == i_rd_addr));

        o_id_ready = !i_flush
                  && (!i_rs1_used || (rs1_eff == '0))
                  && (!i_rs2_used || (rs2_eff == '0))
                  && (!i_rd_wen   || (rd_eff != CNT_MAX));

        issue  = i_id_valid && o_id_ready;
        rd_inc = issue && i_rd_wen && (i_rd_addr != 5'd0);

        any_pending = 1'b0;
        for (int i = 1; i < 32; i++) begin
            any_pending = any_pending || (cnt[i] != '0);
        end
    end

    // Pending-write counters: flush clears, issue increments, writeback decrements.
    // NOTE: the counter array needs a reset because it is control state, not data storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (i_flush) begin
                    cnt[i] <= '0;
                end else if (rd_inc && (i_rd_addr == 5'(i))
                             && !(wb_retire && (i_wb_addr == 5'(i)))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (wb_retire && (i_wb_addr == 5'(i))
                             && !(rd_inc && (i_rd_addr == 5'(i)))) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Busy flag lags the counters by one cycle.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_busy <= 1'b0;
        end else begin
            o_busy <= any_pending;
        end
    end

    // Sticky error for a writeback that has no matching pending write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_underflow <= 1'b0;
        end else if (!i_flush && wb_underflow) begin
            o_underflow <= 1'b1;
        end
    end

    // Saturating count of cycles where a valid instruction was held back.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
        end else if (i_id_valid && !o_id_ready && !i_flush && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bc_id_scoreboard.sv
// tb_bc_id_scoreboard: scoreboard bench for bc_id_scoreboard.
// The driver applies one cycle of inputs per call, computes the expected
// response from a pending-write table and queues it; an independent monitor
// pops the queue and compares against the DUT outputs.

module tb_bc_id_scoreboard;

    localparam int CNT_MAX = 3;

    typedef struct {
        logic        ready;
        logic        busy;
        logic        uf;
        logic [31:0] stall;
    } exp_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_id_valid;
    logic        o_id_ready;
    logic        i_rs1_used;
    logic [4:0]  i_rs1_addr;
    logic        i_rs2_used;
    logic [4:0]  i_rs2_addr;
    logic        i_rd_wen;
    logic [4:0]  i_rd_addr;
    logic        i_wb_valid;
    logic [4:0]  i_wb_addr;
    logic        i_flush;
    logic        o_busy;
    logic        o_underflow;
    logic [31:0] o_stall_cnt;

    bc_id_scoreboard #(.CNT_WIDTH(2), .STALL_CNT_WIDTH(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_id_valid  (i_id_valid),
        .o_id_ready  (o_id_ready),
        .i_rs1_used  (i_rs1_used),
        .i_rs1_addr  (i_rs1_addr),
        .i_rs2_used  (i_rs2_used),
        .i_rs2_addr  (i_rs2_addr),
        .i_rd_wen    (i_rd_wen),
        .i_rd_addr   (i_rd_addr),
        .i_wb_valid  (i_wb_valid),
        .i_wb_addr   (i_wb_addr),
        .i_flush     (i_flush),
        .o_busy      (o_busy),
        .o_underflow (o_underflow),
        .o_stall_cnt (o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Reference model: number of outstanding writes per register.
    int          pend [32];
    logic        m_uf;
    logic [31:0] m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit model_any_pending();
        for (int r = 1; r < 32; r++) begin
            if (pend[r] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) pend[r] = 0;
        m_uf    = 1'b0;
        m_stall = '0;
    endtask

    // Outstanding writes to register a as seen by decode this cycle.
    function automatic int eff(input int a, input bit wbv, input int wba);
        if (a == 0) return 0;
        if (wbv && wba == a && pend[a] > 0) return pend[a] - 1;
        return pend[a];
    endfunction

    // One cycle of stimulus; queues the expected outcome and advances the model.
    task automatic drive(input bit v, input bit r1u, input int r1, input bit r2u, input int r2,
                         input bit wen, input int rd, input bit wbv, input int wba, input bit fl);
        exp_t e;
        bit   rdy;
        @(negedge i_clk);
        i_id_valid = v;
        i_rs1_used = r1u; i_rs1_addr = 5'(r1);
        i_rs2_used = r2u; i_rs2_addr = 5'(r2);
        i_rd_wen   = wen; i_rd_addr  = 5'(rd);
        i_wb_valid = wbv; i_wb_addr  = 5'(wba);
        i_flush    = fl;
        #1;
        rdy = !fl
           && (!r1u || eff(r1, wbv, wba) == 0)
           && (!r2u || eff(r2, wbv, wba) == 0)
           && (!wen || eff(rd, wbv, wba) < CNT_MAX);
        if (v && !rdy && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
        e.busy = model_any_pending();
        if (fl) begin
            for (int r = 0; r < 32; r++) pend[r] = 0;
        end else begin
            if (wbv && wba != 0) begin
                if (pend[wba] > 0) pend[wba]--;
                else m_uf = 1'b1;
            end
            if (v && rdy && wen && rd != 0) pend[rd]++;
        end
        e.ready = rdy;
        e.uf    = m_uf;
        e.stall = m_stall;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse between edges; call ~2ns after a rising edge.
    task automatic pulse_reset();
        i_id_valid = 0; i_rs1_used = 0; i_rs2_used = 0; i_rd_wen = 0;
        i_wb_valid = 0; i_flush = 0;
        i_rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, o_id_ready}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_underflow", {31'd0, o_underflow}, 32'd0);
        check("rst_stall_cnt", o_stall_cnt, 32'd0);
        i_flush = 1'b1;
        #1;
        check("rst_ready_flush", {31'd0, o_id_ready}, 32'd0);
        i_flush = 1'b0;
        i_rst = 1'b0;
        model_reset();
    endtask

    // Monitor: combinational ready mid-cycle, registered outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            #2;
            if (exp_q.size() > 0) check("id_ready", {31'd0, o_id_ready}, {31'd0, exp_q[0].ready});
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("busy", {31'd0, o_busy}, {31'd0, e.busy});
                check("underflow", {31'd0, o_underflow}, {31'd0, e.uf});
                check("stall_cnt", o_stall_cnt, e.stall);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_id_valid = 0; i_rs1_used = 0; i_rs1_addr = 0; i_rs2_used = 0; i_rs2_addr = 0;
        i_rd_wen = 0; i_rd_addr = 0; i_wb_valid = 0; i_wb_addr = 0; i_flush = 0;
        model_reset();
        @(posedge i_clk); #2;
        pulse_reset();

        // RAW stall on x5, released by same-cycle writeback bypass
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        repeat (3) drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        idle(); idle();

        // x0 destination and sources, unused rs2 with pending x7
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(); idle();
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        drive(1, 1, 0, 0, 7, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 7, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Destination counter saturation on x9
        repeat (3) drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        idle(); idle();

        // Simultaneous issue and writeback on x3
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 3, 1, 3, 0);
        idle(); idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        idle(); idle();

        // Underflow on x12, then flush with x4/x8 pending
        drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        idle();
        drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        drive(1, 1, 4, 0, 0, 1, 6, 0, 0, 1);
        idle(); idle();

        // Randomized traffic on a narrow register window to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            bit fl;
            fl = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 15),
                  1'($urandom), $urandom_range(0, 15),
                  1'($urandom), $urandom_range(0, 15),
                  fl ? 1'b0 : ($urandom_range(0, 2) != 0), $urandom_range(0, 15),
                  fl);
        end

        // Build stall count 17 with x5 pending, then reset asynchronously
        @(posedge i_clk); #2;
        pulse_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        repeat (17) drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        @(posedge i_clk); #2;
        check("stall_before_rst", o_stall_cnt, 32'd17);
        check("busy_before_rst", {31'd0, o_busy}, 32'd1);
        pulse_reset();

        // Writeback to x5 after reset finds an empty counter
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        idle(); idle();

        @(posedge i_clk); #3;
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
